// File: rtl/minterm_func_pipe_if.sv
//------------------------------------------------------------------------------
// Module      : minterm_func_pipe_if
// Description : Evaluation handshake and serial mask-config bundle for
//               minterm_func_pipe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface minterm_func_pipe_if #(
   parameter int N_IN = 4
);
   localparam int c_d = 2**N_IN;

   logic              in_valid;
   logic              in_ready;
   logic [N_IN-1:0]   in_a;
   logic              in_inv;
   logic              out_valid;
   logic              out_ready;
   logic              out_f;
   logic [c_d-1:0]    out_onehot;
   logic              cfg_start;
   logic              cfg_bit_valid;
   logic              cfg_bit;
   logic              cfg_abort;
   logic              cfg_busy;
   logic              cfg_done;

   modport master (
      output in_valid, in_a, in_inv, out_ready,
             cfg_start, cfg_bit_valid, cfg_bit, cfg_abort,
      input  in_ready, out_valid, out_f, out_onehot, cfg_busy, cfg_done
   );

   modport slave (
      input  in_valid, in_a, in_inv, out_ready,
             cfg_start, cfg_bit_valid, cfg_bit, cfg_abort,
      output in_ready, out_valid, out_f, out_onehot, cfg_busy, cfg_done
   );
endinterface

`default_nettype wire

// File: rtl/minterm_func_pipe.sv
//------------------------------------------------------------------------------
// Module      : minterm_func_pipe
// Description : Programmable N-input Boolean function (minterm mask) with a
//               2-stage valid/ready pipeline and serial mask reload.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module minterm_func_pipe #(
   parameter int                N_IN       = 4,
   parameter logic [2**N_IN-1:0] RESET_MASK = 16'h8D9D
) (
   input logic                clk,
   input logic                rst_n,
   minterm_func_pipe_if.slave bus
);
   localparam int c_d = 2**N_IN;
   localparam logic [c_d-1:0]  c_onehot_lsb = {{(c_d-1){1'b0}}, 1'b1};
   localparam logic [N_IN-1:0] c_cnt_one    = {{(N_IN-1){1'b0}}, 1'b1};
   localparam logic [N_IN-1:0] c_cnt_last   = {N_IN{1'b1}};

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_shift  = 2'd1;
   localparam logic [1:0] c_st_commit = 2'd2;

   logic              r_s1_valid;
   logic              r_s1_inv;
   logic [c_d-1:0]    r_s1_onehot;
   logic              r_out_valid;
   logic              r_out_f;
   logic [c_d-1:0]    r_out_onehot;
   logic [c_d-1:0]    r_mask;
   logic [c_d-1:0]    r_shadow;
   logic [N_IN-1:0]   r_cnt;
   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              w_adv1;
   logic              w_adv2;
   logic              w_bit_xfer;
   logic              w_last_bit;
   logic              w_busy;
   logic              w_done;

   assign w_adv2 = !r_out_valid || bus.out_ready;
   assign w_adv1 = !r_s1_valid || w_adv2;

   assign bus.in_ready   = w_adv1;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_f      = r_out_f;
   assign bus.out_onehot = r_out_onehot;
   assign bus.cfg_busy   = w_busy;
   assign bus.cfg_done   = w_done;

   // Stage 1: one-hot decode of the accepted vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_inv    <= 1'b0;
         r_s1_onehot <= '0;
      end else if (w_adv1) begin
         r_s1_valid  <= bus.in_valid;
         r_s1_inv    <= bus.in_inv;
         r_s1_onehot <= c_onehot_lsb << bus.in_a;
      end
   end

   // Stage 2 samples r_mask before any same-edge commit, so it sees the old mask
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_f      <= 1'b0;
         r_out_onehot <= '0;
      end else if (w_adv2) begin
         r_out_valid  <= r_s1_valid;
         r_out_f      <= (|(r_s1_onehot & r_mask)) ^ r_s1_inv;
         r_out_onehot <= r_s1_onehot;
      end
   end

   assign w_bit_xfer = (r_state == c_st_shift) && !bus.cfg_abort && bus.cfg_bit_valid;
   assign w_last_bit = w_bit_xfer && (r_cnt == c_cnt_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (bus.cfg_start) begin
               w_state_nxt = c_st_shift;
            end
         end
         c_st_shift: begin
            if (bus.cfg_abort) begin
               w_state_nxt = c_st_idle;
            end else if (w_last_bit) begin
               w_state_nxt = c_st_commit;
            end
         end
         c_st_commit: begin
            w_state_nxt = c_st_idle;
         end
         default: begin
            w_state_nxt = c_st_idle;
         end
      endcase
   end

   always_comb begin
      w_busy = (r_state != c_st_idle);
      w_done = (r_state == c_st_commit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_shadow <= '0;
         r_mask   <= RESET_MASK;
      end else begin
         if ((r_state == c_st_idle) && bus.cfg_start) begin
            r_cnt <= '0;
         end else if (w_bit_xfer) begin
            r_shadow[r_cnt] <= bus.cfg_bit;
            r_cnt           <= r_cnt + c_cnt_one;
         end
         if (r_state == c_st_commit) begin
            r_mask <= r_shadow;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_minterm_func_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_minterm_func_pipe
// Description : Randomised self-checking bench with a queue-based reference.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_minterm_func_pipe;
   localparam int          N_IN       = 4;
   localparam logic [15:0] RESET_MASK = 16'h8D9D;
   localparam int          c_never    = 32'h7fff_ffff;

   typedef struct {
      logic [3:0] a;
      logic       inv;
      int         acc;   // edge at which the item was accepted
   } item_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   item_t       expq[$];
   int          errors = 0;
   int          checks = 0;
   int          edge_n = 0;
   logic [15:0] old_mask = RESET_MASK;
   logic [15:0] new_mask = RESET_MASK;
   int          commit_edge = c_never;

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   minterm_func_pipe_if #(.N_IN(N_IN)) bus ();

   minterm_func_pipe #(.N_IN(N_IN), .RESET_MASK(RESET_MASK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic idle_inputs();
      bus.in_valid      = 1'b0;
      bus.in_a          = '0;
      bus.in_inv        = 1'b0;
      bus.out_ready     = 1'b1;
      bus.cfg_start     = 1'b0;
      bus.cfg_bit_valid = 1'b0;
      bus.cfg_bit       = 1'b0;
      bus.cfg_abort     = 1'b0;
   endtask

   // One clock: check pops against the model at negedge, record accepts, land at posedge+1.
   // An item captured into stage 2 after the commit edge uses the new mask.
   task automatic cycle();
      item_t       it;
      logic [15:0] m;
      logic [15:0] oh;
      logic        ef;
      logic        exp_rdy;
      @(negedge clk);
      exp_rdy = (expq.size() < 2) || bus.out_ready;
      checks++;
      if (bus.in_ready !== exp_rdy) begin
         errors++;
         $display("FAIL in_ready: got %b want %b (edge %0d)", bus.in_ready, exp_rdy, edge_n);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL extra_output: got out_valid=1 want no pending result (edge %0d)", edge_n);
         end else begin
            it = expq.pop_front();
            m  = (it.acc + 1 > commit_edge) ? new_mask : old_mask;
            ef = m[it.a] ^ it.inv;
            oh = 16'h0001 << it.a;
            checks++;
            if (bus.out_f !== ef) begin
               errors++;
               $display("FAIL out_f a=%0d inv=%b: got %b want %b", it.a, it.inv, bus.out_f, ef);
            end
            if (bus.out_onehot !== oh) begin
               errors++;
               $display("FAIL out_onehot a=%0d: got %h want %h", it.a, bus.out_onehot, oh);
            end
         end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
         it.a   = bus.in_a;
         it.inv = bus.in_inv;
         it.acc = edge_n + 1;
         expq.push_back(it);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(string name);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d results missing want 0", name, expq.size());
         expq.delete();
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      checks += 6;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      if (bus.out_f !== 1'b0) begin errors++; $display("FAIL reset_out_f: got %b want 0", bus.out_f); end
      if (bus.out_onehot !== 16'h0) begin errors++; $display("FAIL reset_onehot: got %h want 0000", bus.out_onehot); end
      if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.cfg_busy); end
      if (bus.cfg_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.cfg_done); end
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_stream();
      logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd15, 4'd5};
      logic       exp_v;
      for (int k = 0; k < 8; k++) begin
         bus.in_valid = (k < 4);
         bus.in_a     = (k < 4) ? seq[k] : 4'd0;
         bus.in_inv   = 1'b0;
         exp_v        = (k >= 2) && (k <= 5);
         checks++;
         if (bus.out_valid !== exp_v) begin
            errors++;
            $display("FAIL stream_latency k=%0d: got out_valid=%b want %b", k, bus.out_valid, exp_v);
         end
         cycle();
      end
      drain("stream");
   endtask

   task automatic test_sweep();
      for (int inv = 0; inv < 2; inv++) begin
         for (int a = 0; a < 16; a++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 4'(a);
            bus.in_inv   = inv[0];
            cycle();
         end
      end
      drain("sweep");
   endtask

   task automatic test_stall();
      logic [15:0] held_oh;
      logic        held_f;
      held_oh = '0;
      held_f  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.in_a   = 4'($urandom_range(0, 15));
         bus.in_inv = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (bus.in_ready !== (k < 2)) begin
            errors++;
            $display("FAIL stall_in_ready k=%0d: got %b want %b", k, bus.in_ready, (k < 2));
         end
         if (k == 2) begin
            held_oh = bus.out_onehot;
            held_f  = bus.out_f;
         end else if (k > 2) begin
            checks++;
            if (bus.out_onehot !== held_oh || bus.out_f !== held_f || bus.out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold k=%0d: got %h/%b want %h/%b", k, bus.out_onehot, bus.out_f, held_oh, held_f);
            end
         end
         cycle();
      end
      checks++;
      if (expq.size() != 2) begin
         errors++;
         $display("FAIL stall_buffered: got %0d items want 2", expq.size());
      end
      drain("stall");
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 1) != 0);
         bus.in_a      = 4'($urandom_range(0, 15));
         bus.in_inv    = 1'($urandom_range(0, 1));
         cycle();
      end
      drain("random");
   endtask

   task automatic test_abort();
      int dones = 0;
      bus.cfg_start = 1'b1;
      cycle();
      bus.cfg_start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         bus.cfg_bit_valid = 1'b1;
         bus.cfg_bit       = 1'($urandom_range(0, 1));
         checks++;
         if (bus.cfg_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_shift k=%0d: got %b want 1", k, bus.cfg_busy);
         end
         cycle();
      end
      bus.cfg_abort     = 1'b1;
      bus.cfg_bit_valid = 1'b1;
      cycle();
      bus.cfg_abort     = 1'b0;
      bus.cfg_bit_valid = 1'b0;
      checks++;
      if (bus.cfg_busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy: got %b want 0", bus.cfg_busy);
      end
      for (int k = 0; k < 20; k++) begin
         if (bus.cfg_done === 1'b1) dones++;
         cycle();
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL abort_done: got %0d pulses want 0", dones);
      end
      test_sweep();
   endtask

   task automatic test_cfg_load();
      logic [15:0] nm;
      int          sent = 0;
      int          e16 = c_never;
      int          start_edge = c_never;
      int          dones = 0;
      logic        exp_busy;
      logic        exp_done;
      nm       = 16'h0001;
      new_mask = nm;
      for (int k = 0; k < 200 && !(sent == 16 && edge_n > e16 + 3); k++) begin
         bus.in_valid      = 1'b1;
         bus.in_a          = (k % 2 == 1) ? 4'd2 : 4'd0;
         bus.in_inv        = 1'b0;
         bus.cfg_start     = (k == 0);
         bus.cfg_bit_valid = 1'b0;
         if (k == 0) start_edge = edge_n + 1;
         if (k > 0 && sent < 16 && $urandom_range(0, 2) != 0) begin
            bus.cfg_bit_valid = 1'b1;
            bus.cfg_bit       = nm[sent];
            sent++;
            if (sent == 16) begin
               e16         = edge_n + 1;
               commit_edge = e16 + 1;
            end
         end
         exp_busy = (edge_n >= start_edge) && (edge_n <= e16);
         exp_done = (edge_n == e16);
         if (bus.cfg_done === 1'b1) dones++;
         checks += 2;
         if (bus.cfg_busy !== exp_busy) begin
            errors++;
            $display("FAIL cfg_busy edge %0d: got %b want %b", edge_n, bus.cfg_busy, exp_busy);
         end
         if (bus.cfg_done !== exp_done) begin
            errors++;
            $display("FAIL cfg_done edge %0d: got %b want %b", edge_n, bus.cfg_done, exp_done);
         end
         cycle();
      end
      bus.cfg_start     = 1'b0;
      bus.cfg_bit_valid = 1'b0;
      checks++;
      if (dones != 1 || sent != 16) begin
         errors++;
         $display("FAIL cfg_done_count: got %0d pulses (%0d bits sent) want 1 (16)", dones, sent);
      end
      drain("cfg_load");
      old_mask    = new_mask;
      commit_edge = c_never;
   endtask

   task automatic test_reset_midload();
      bus.cfg_start = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = 4'($urandom_range(0, 15));
      cycle();
      bus.cfg_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.cfg_bit_valid = 1'b1;
         bus.cfg_bit       = 1'($urandom_range(0, 1));
         bus.in_a          = 4'($urandom_range(0, 15));
         cycle();
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b want 0", bus.out_valid); end
      if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", bus.cfg_busy); end
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", bus.in_ready); end
      expq.delete();
      old_mask    = RESET_MASK;
      new_mask    = RESET_MASK;
      commit_edge = c_never;
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_a     = 4'd7;
      bus.in_inv   = 1'b0;
      cycle();
      bus.in_valid = 1'b0;
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_f !== 1'b1) begin
         errors++;
         $display("FAIL midreset_a7: got valid=%b f=%b want valid=1 f=1", bus.out_valid, bus.out_f);
      end
      drain("midreset");
   endtask

   initial begin
      test_reset();
      test_stream();
      test_sweep();
      test_stall();
      test_random();
      test_abort();
      test_cfg_load();
      test_reset_midload();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
